// File: rtl/sp_pkg.sv
// Shared definitions for the comma-aligning serial-to-parallel converter.
package sp_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sp_state_e;

  localparam logic [7:0] SP_COM_K285 = 8'hBC;
  localparam logic [7:0] SP_IDL      = 8'h7C;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int sp_bit_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sp_align_fsm.sv
// Alignment/lock controller: owns state, com_cnt, bit_cnt and the loss counter.
// Optional loss-of-lock detection is enabled with `define SP_LOSS_DETECT_EN.
module sp_align_fsm
  import sp_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_WIN = 16
) (
  input  logic clk32f,
  input  logic reset,
  input  logic cand_is_com,
  output logic boundary,
  output logic locked,
  output logic lose
);

  localparam int CNT_W  = sp_bit_w(WIDTH);
  localparam int LOSS_W = sp_bit_w(LOSS_WIN);
`ifdef SP_LOSS_DETECT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  sp_state_e          state, state_nxt;
  logic [3:0]         com_cnt, com_cnt_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [LOSS_W-1:0]  loss_cnt, loss_cnt_nxt;

  assign boundary = (bit_cnt == CNT_W'(WIDTH - 1));
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      com_cnt  <= '0;
      bit_cnt  <= '0;
      loss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      com_cnt  <= com_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      loss_cnt <= loss_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    com_cnt_nxt  = com_cnt;
    bit_cnt_nxt  = boundary ? '0 : bit_cnt + CNT_W'(1);
    loss_cnt_nxt = loss_cnt;
    lose         = 1'b0;
    case (state)
      SEARCH: begin
        // Any bit offset may start a word: re-phase the bit counter on the COM.
        if (cand_is_com) begin
          bit_cnt_nxt  = '0;
          com_cnt_nxt  = 4'd1;
          loss_cnt_nxt = '0;
          state_nxt    = (LOCK_CNT == 1) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (cand_is_com) begin
            com_cnt_nxt = com_cnt + 4'd1;
            if (com_cnt + 4'd1 == 4'(LOCK_CNT)) begin
              state_nxt    = LOCKED;
              loss_cnt_nxt = '0;
            end
          end else begin
            state_nxt   = SEARCH;
            com_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (LOSS_EN && boundary) begin
          if (cand_is_com) begin
            loss_cnt_nxt = '0;
          end else if (loss_cnt == LOSS_W'(LOSS_WIN - 1)) begin
            lose         = 1'b1;
            state_nxt    = SEARCH;
            com_cnt_nxt  = '0;
            loss_cnt_nxt = '0;
          end else begin
            loss_cnt_nxt = loss_cnt + LOSS_W'(1);
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

endmodule

// File: rtl/serieparalelo_align.sv
// Serial-to-parallel converter with comma bit-alignment and lock detection.
// Optional loss-of-lock detection is enabled with `define SP_LOSS_DETECT_EN.
module serieparalelo_align
  import sp_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] COM      = WIDTH'(SP_COM_K285),
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_WIN = 16
) (
  input  logic             clk32f,
  input  logic             reset,
  input  logic             in,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             word_stb,
  output logic             active
);

  // Only the newest WIDTH-1 bits are needed; the current bit completes the word.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] cand;
  logic             cand_is_com;
  logic             boundary;
  logic             locked;
  logic             lose;

  assign cand        = {sr, in};
  assign cand_is_com = (cand == COM);
  assign active      = locked;

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= cand[WIDTH-2:0];
  end

  sp_align_fsm #(
    .WIDTH    (WIDTH),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_WIN (LOSS_WIN)
  ) u_fsm (
    .clk32f      (clk32f),
    .reset       (reset),
    .cand_is_com (cand_is_com),
    .boundary    (boundary),
    .locked      (locked),
    .lose        (lose)
  );

  // Word presentation: one strobe per aligned word while locked; out holds between.
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      out      <= '0;
      valid    <= 1'b0;
      word_stb <= 1'b0;
    end else if (locked && boundary && !lose) begin
      out      <= cand;
      valid    <= !cand_is_com;
      word_stb <= 1'b1;
    end else begin
      word_stb <= 1'b0;
      if (!locked || lose) valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serieparalelo_align.sv
// Bench for serieparalelo_align: table vectors, directed corner sequences and
// a randomized stream checked against a word-level reference model.
module tb_serieparalelo_align;
  import sp_pkg::*;

  localparam int         W   = 8;
  localparam int         LC  = 4;
  localparam int         LW  = 16;
  localparam logic [7:0] COM = SP_COM_K285;
`ifdef SP_LOSS_DETECT_EN
  localparam bit LOSS_ON = 1'b1;
`else
  localparam bit LOSS_ON = 1'b0;
`endif

  logic         clk32f = 1'b0;
  logic         reset  = 1'b0;
  logic         in     = 1'b0;
  logic [W-1:0] out;
  logic         valid, word_stb, active;

  int n_cmp  = 0;
  int n_fail = 0;

  serieparalelo_align #(.WIDTH(W), .COM(COM), .LOCK_CNT(LC), .LOSS_WIN(LW)) dut (
    .clk32f   (clk32f),
    .reset    (reset),
    .in       (in),
    .out      (out),
    .valid    (valid),
    .word_stb (word_stb),
    .active   (active)
  );

  always #5 clk32f = ~clk32f;

  // Reference model: word phase is tracked as distance from the COM that set it.
  logic [7:0] m_win, m_out;
  bit         m_valid, m_stb;
  int         m_mode, m_ncom, m_quiet;
  longint     m_t, m_anchor;

  task automatic model_reset();
    m_win = '0; m_out = '0; m_valid = 0; m_stb = 0;
    m_mode = 0; m_ncom = 0; m_quiet = 0; m_t = 0; m_anchor = 0;
  endtask

  task automatic model_step(input bit b);
    bit is_com, bnd;
    m_win  = {m_win[6:0], b};
    is_com = (m_win == COM);
    bnd    = (m_t > m_anchor) && (((m_t - m_anchor) % W) == 0);
    m_stb  = 0;
    if (m_mode == 0) begin
      if (is_com) begin
        m_anchor = m_t; m_ncom = 1; m_quiet = 0;
        m_mode = (LC == 1) ? 2 : 1;
      end
    end else if (m_mode == 1 && bnd) begin
      if (is_com) begin
        m_ncom++;
        if (m_ncom == LC) begin m_mode = 2; m_quiet = 0; end
      end else begin
        m_mode = 0; m_ncom = 0;
      end
    end else if (m_mode == 2 && bnd) begin
      if (LOSS_ON && !is_com && m_quiet + 1 == LW) begin
        m_mode = 0; m_valid = 0; m_ncom = 0;
      end else begin
        m_quiet = is_com ? 0 : m_quiet + 1;
        m_out = m_win; m_stb = 1; m_valid = !is_com;
      end
    end
    m_t++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit b);
    in = b;
    @(posedge clk32f);
    model_step(b);
    @(negedge clk32f);
    check("model_out",    32'(out),      32'(m_out));
    check("model_valid",  32'(valid),    32'(m_valid));
    check("model_stb",    32'(word_stb), 32'(m_stb));
    check("model_active", 32'(active),   32'(m_mode == 2));
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(w[i]);
  endtask

  task automatic send_bits(input int n, input logic [7:0] v);
    for (int i = n - 1; i >= 0; i--) step(v[i]);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_out",    32'(out),      0);
    check("rst_valid",  32'(valid),    0);
    check("rst_stb",    32'(word_stb), 0);
    check("rst_active", 32'(active),   0);
    @(negedge clk32f);
    reset = 1'b1;
  endtask

  task automatic lock_up();
    for (int k = 0; k < LC - 1; k++) send_word(COM);
    check("pre_lock_active", 32'(active), 0);
    send_word(COM);
    check("lock_active", 32'(active), 1);
    check("lock_no_stb", 32'(word_stb), 0);
  endtask

  typedef struct {
    int         njunk;
    logic [7:0] junk;
    logic [7:0] data;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int strobes;
    vecs[0] = '{0, 8'h00, 8'h35, 1'b1};
    vecs[1] = '{3, 8'h05, 8'hA5, 1'b1};
    vecs[2] = '{5, 8'h06, 8'h12, 1'b1};
    vecs[3] = '{0, 8'h00, 8'hBC, 1'b0};
    vecs[4] = '{7, 8'h63, 8'h00, 1'b1};

    model_reset();
    repeat (3) @(negedge clk32f);
    check("init_out",    32'(out),    0);
    check("init_active", 32'(active), 0);
    reset = 1'b1;

    foreach (vecs[v]) begin
      do_reset();
      send_bits(vecs[v].njunk, vecs[v].junk);
      lock_up();
      send_word(vecs[v].data);
      check("vec_stb",   32'(word_stb), 1);
      check("vec_out",   32'(out),      32'(vecs[v].data));
      check("vec_valid", 32'(valid),    32'(vecs[v].exp_valid));
    end

    // Broken COM run falls back to search, a complete run locks.
    do_reset();
    for (int k = 0; k < 3; k++) send_word(COM);
    send_word(8'h00);
    check("broken_run_active", 32'(active), 0);
    lock_up();

    // COM and data words while locked.
    send_word(COM);
    check("com_word_stb",   32'(word_stb), 1);
    check("com_word_out",   32'(out),      32'(COM));
    check("com_word_valid", 32'(valid),    0);
    send_word(8'h12);
    check("data_word_stb",   32'(word_stb), 1);
    check("data_word_out",   32'(out),      32'h12);
    check("data_word_valid", 32'(valid),    1);
    step(1'b0);
    check("offboundary_stb", 32'(word_stb), 0);
    check("hold_out",        32'(out),      32'h12);

    // Mid-word reset while locked, then relock from scratch.
    send_bits(3, 8'h05);
    do_reset();
    lock_up();

    // Long run without COM.
    strobes = 0;
    for (int k = 0; k < LW; k++) begin
      send_word(8'h55);
      if (word_stb) strobes++;
    end
    check("loss_strobes", 32'(strobes), LOSS_ON ? LW - 1 : LW);
    check("loss_active",  32'(active),  LOSS_ON ? 0 : 1);

    // Randomized stream of COMs, idles, data and slips.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30)      send_word(COM);
      else if (r < 40) send_word(SP_IDL);
      else if (r < 48) send_bits($urandom_range(1, 7), 8'($urandom));
      else if (r < 49) do_reset();
      else             send_word(8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
